// File: rtl/repetition_encoder_tx_if.sv
// Handshake bundle for the repetition encoder: word side (producer) and symbol side (line driver).
interface repetition_encoder_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_bit;
    logic              tx_last;
    logic              busy;

    modport master (
        output in_valid, in_data, tx_ready,
        input  in_ready, tx_valid, tx_bit, tx_last, busy
    );

    modport slave (
        input  in_valid, in_data, tx_ready,
        output in_ready, tx_valid, tx_bit, tx_last, busy
    );
endinterface

// File: rtl/repetition_encoder_tx.sv
// Repetition-code transmitter: serialises each word MSB first and emits every bit REP times
// so the far end can majority-vote each group.
module repetition_encoder_tx #(
    parameter int DATA_W = 8,
    parameter int REP    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    repetition_encoder_tx_if.slave bus
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int REP_W = (REP > 1) ? $clog2(REP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [REP_W-1:0] LAST_REP = REP_W'(REP - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic [REP_W-1:0]  rep_cnt;

    logic send;
    logic last_sym;
    logic consume;
    logic accept;

    // Everything the line driver sees is decoded from registers only.
    assign send     = (state == SEND);
    assign last_sym = send && (bit_idx == LAST_IDX) && (rep_cnt == LAST_REP);
    assign consume  = send && bus.tx_ready;
    // Ready during the final symbol's consume lets the next word follow with no idle cycle.
    assign accept   = bus.in_valid && bus.in_ready;

    assign bus.in_ready = !send || (last_sym && bus.tx_ready);
    assign bus.tx_valid = send;
    assign bus.tx_bit   = send && shreg[DATA_W-1];
    assign bus.tx_last  = last_sym;
    assign bus.busy     = send;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make the result depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            rep_cnt <= '0;
        end else if (accept) begin
            // Fresh load wins over the final consume: that symbol leaves as the new word arrives.
            state   <= SEND;
            shreg   <= bus.in_data;
            bit_idx <= '0;
            rep_cnt <= '0;
        end else if (consume) begin
            if (rep_cnt != LAST_REP) begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end else begin
                rep_cnt <= '0;
                shreg   <= shreg << 1;
                if (last_sym) begin
                    state   <= IDLE;
                    bit_idx <= '0;
                end else begin
                    bit_idx <= bit_idx + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_repetition_encoder_tx.sv
// Bench for repetition_encoder_tx: a symbol-queue model checked every cycle, plus literal
// expectations for the directed word scenarios.
module tb_repetition_encoder_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    repetition_encoder_tx_if #(.DATA_W(8)) ifa ();
    repetition_encoder_tx_if #(.DATA_W(4)) ifb ();

    repetition_encoder_tx #(.DATA_W(8), .REP(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    repetition_encoder_tx #(.DATA_W(4), .REP(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted word becomes DATA_W*REP queued symbols {bit, last}; the front is on the line.
    logic [1:0] qa[$];
    logic [1:0] qb[$];

    always @(posedge clk or negedge rst_n) begin
        bit rdy;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            rdy = (qa.size() == 0) || (qa.size() == 1 && ifa.tx_ready);
            if (qa.size() > 0 && ifa.tx_ready) void'(qa.pop_front());
            if (ifa.in_valid && rdy)
                for (int i = 7; i >= 0; i--)
                    for (int r = 0; r < 3; r++) qa.push_back({ifa.in_data[i], (i == 0 && r == 2)});
            rdy = (qb.size() == 0) || (qb.size() == 1 && ifb.tx_ready);
            if (qb.size() > 0 && ifb.tx_ready) void'(qb.pop_front());
            if (ifb.in_valid && rdy)
                for (int i = 3; i >= 0; i--) qb.push_back({ifb.in_data[i], (i == 0)});
        end
    end

    // Captured traffic for the literal expectations.
    bit cap_a[$];
    bit cap_b[$];
    int last_a[$];
    int last_b[$];
    int vcyc_a = 0;
    int vcyc_b = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("a_tx_valid", ifa.tx_valid, qa.size() > 0);
            check("a_tx_bit",   ifa.tx_bit,   qa.size() > 0 ? qa[0][1] : 1'b0);
            check("a_tx_last",  ifa.tx_last,  qa.size() > 0 ? qa[0][0] : 1'b0);
            check("a_busy",     ifa.busy,     qa.size() > 0);
            check("a_in_ready", ifa.in_ready, (qa.size() == 0) || (qa.size() == 1 && ifa.tx_ready));
            check("b_tx_valid", ifb.tx_valid, qb.size() > 0);
            check("b_tx_bit",   ifb.tx_bit,   qb.size() > 0 ? qb[0][1] : 1'b0);
            check("b_tx_last",  ifb.tx_last,  qb.size() > 0 ? qb[0][0] : 1'b0);
            check("b_in_ready", ifb.in_ready, (qb.size() == 0) || (qb.size() == 1 && ifb.tx_ready));
            if (ifa.tx_valid) vcyc_a++;
            if (ifb.tx_valid) vcyc_b++;
            if (ifa.tx_valid && ifa.tx_ready) begin
                cap_a.push_back(ifa.tx_bit);
                if (ifa.tx_last) last_a.push_back(cap_a.size());
            end
            if (ifb.tx_valid && ifb.tx_ready) begin
                cap_b.push_back(ifb.tx_bit);
                if (ifb.tx_last) last_b.push_back(cap_b.size());
            end
        end
    end

    function automatic logic [63:0] pack(input bit q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = {v[62:0], q[i]};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_a.delete();
        cap_b.delete();
        last_a.delete();
        last_b.delete();
        vcyc_a = 0;
        vcyc_b = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_tx_valid"}, ifa.tx_valid, 0);
        check({tag, "_a_tx_bit"},   ifa.tx_bit,   0);
        check({tag, "_a_tx_last"},  ifa.tx_last,  0);
        check({tag, "_a_busy"},     ifa.busy,     0);
        check({tag, "_b_tx_valid"}, ifb.tx_valid, 0);
    endtask

    task automatic send_a(input logic [7:0] w);
        ifa.in_valid = 1'b1;
        ifa.in_data  = w;
        tick();
        ifa.in_valid = 1'b0;
        ifa.in_data  = '0;
    endtask

    initial begin
        ifa.in_valid = 0; ifa.in_data = '0; ifa.tx_ready = 0;
        ifb.in_valid = 0; ifb.in_data = '0; ifb.tx_ready = 0;

        // 1: reset state, then a mid-clock reset pulse
        #2 check_reset_outputs("por");
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", ifa.in_ready, 1);
        check("rel_busy",     ifa.busy,     0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        #1 rst_n = 1'b1;
        tick();
        check("rel2_in_ready", ifa.in_ready, 1);
        check("rel2_busy",     ifa.busy,     0);

        // 2: 8'hA5 with the line always ready
        clear_caps();
        ifa.tx_ready = 1'b1;
        send_a(8'hA5);
        repeat (30) tick();
        check("a5_seq",    pack(cap_a), 64'(24'b111000111000000111000111));
        check("a5_count",  cap_a.size(), 24);
        check("a5_vcyc",   vcyc_a, 24);
        check("a5_nlast",  last_a.size(), 1);
        check("a5_lastpos", last_a.size() > 0 ? last_a[0] : -1, 24);
        check("a5_idle_ready", ifa.in_ready, 1);

        // 3: stalls on symbols 5 and 24, two cycles each
        clear_caps();
        send_a(8'hA5);
        for (int c = 1; c <= 32; c++) begin
            ifa.tx_ready = !(c inside {5, 6, 26, 27});
            tick();
        end
        ifa.tx_ready = 1'b1;
        check("stall_seq",     pack(cap_a), 64'(24'b111000111000000111000111));
        check("stall_vcyc",    vcyc_a, 28);
        check("stall_lastpos", last_a.size() > 0 ? last_a[0] : -1, 24);

        // 4: back-to-back 8'hFF then 8'h00 with in_valid held
        clear_caps();
        ifa.in_valid = 1'b1;
        ifa.in_data  = 8'hFF;
        tick();
        ifa.in_data = 8'h00;
        repeat (23) tick();
        check("b2b_last_at_24",  ifa.tx_last, 1);
        check("b2b_ready_at_24", ifa.in_ready, 1);
        tick();
        ifa.in_valid = 1'b0;
        check("b2b_second_msb_valid", ifa.tx_valid, 1);
        repeat (30) tick();
        check("b2b_seq",   pack(cap_a), {16'h0, 24'hFFFFFF, 24'h000000});
        check("b2b_vcyc",  vcyc_a, 48);
        check("b2b_nlast", last_a.size(), 2);
        check("b2b_last2", last_a.size() > 1 ? last_a[1] : -1, 48);

        // 5: reset after 10 symbols of 8'h3C, then 8'h81
        send_a(8'h3C);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midword");
        #3 rst_n = 1'b1;
        tick();
        check("rst_ready", ifa.in_ready, 1);
        clear_caps();
        send_a(8'h81);
        repeat (28) tick();
        check("r81_seq",  pack(cap_a), 64'(24'b111000000000000000000111));
        check("r81_vcyc", vcyc_a, 24);

        // 6: REP=1, DATA_W=4 instance
        clear_caps();
        ifb.tx_ready = 1'b1;
        ifb.in_valid = 1'b1;
        ifb.in_data  = 4'b1010;
        tick();
        ifb.in_valid = 1'b0;
        repeat (8) tick();
        check("rep1_seq",     pack(cap_b), 64'(4'b1010));
        check("rep1_vcyc",    vcyc_b, 4);
        check("rep1_nlast",   last_b.size(), 1);
        check("rep1_lastpos", last_b.size() > 0 ? last_b[0] : -1, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
